alu_seq_ctrl: RTL

- Multi-cycle sequencer that owns the execute-stage ALU for ALU-class and branch instructions.
- Accepts one request at a time over a valid/ready handshake and decodes funct3/funct7b5/immediate/branch into the ALU's operation and control inputs.
- Does not receive comparison flags from anywhere else. It derives lt/ltu itself with a preliminary SUB pass, then feeds them back to the ALU for SLT/SLTU.
- Returns a registered result and a branch-taken flag over a second valid/ready handshake.

---
 rtl/alu_seq_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// Execute-stage ALU sequencer: decodes ALU/branch requests, drives an
// external ALU over one or two passes, and returns a registered response.
module alu_seq_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [2:0]       req_funct3,
  input  logic             req_funct7b5,
  input  logic             req_is_imm,
  input  logic             req_is_branch,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_operation,
  output logic             alu_control,
  output logic             alu_lt,
  output logic             alu_ltu,
  input  logic [31:0]      alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_taken,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    EXEC,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [2:0]       f3_q, f3_d;
  logic             f7_q, f7_d;
  logic             imm_q, imm_d;
  logic             br_q, br_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             ltu_q, ltu_d;
  logic [31:0]      res_q, res_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic sdiff, eq_c, lt_c, ltu_c, taken_c;

  // Sign-split handling keeps lt/ltu correct when a-b overflows.
  always_comb begin
    sdiff = a_q[31] ^ b_q[31];
    eq_c  = (alu_result == 32'd0);
    lt_c  = sdiff ? a_q[31] : alu_result[31];
    ltu_c = sdiff ? b_q[31] : alu_result[31];
  end

  always_comb begin
    taken_c = 1'b0;
    unique case (f3_q)
      3'b000:  taken_c = eq_c;
      3'b001:  taken_c = !eq_c;
      3'b100:  taken_c = lt_c;
      3'b101:  taken_c = !lt_c;
      3'b110:  taken_c = ltu_c;
      3'b111:  taken_c = !ltu_c;
      default: taken_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    f3_d    = f3_q;
    f7_d    = f7_q;
    imm_d   = imm_q;
    br_d    = br_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    ltu_d   = ltu_q;
    res_d   = res_q;
    taken_d = taken_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d   = req_a;
          b_d   = req_b;
          f3_d  = req_funct3;
          f7_d  = req_funct7b5;
          imm_d = req_is_imm;
          br_d  = req_is_branch;
          eq_d  = 1'b0;
          lt_d  = 1'b0;
          ltu_d = 1'b0;
          if (req_is_branch || req_funct3[2:1] == 2'b01)
            state_d = CMP;
          else
            state_d = EXEC;
        end
      end
      CMP: begin
        eq_d  = eq_c;
        lt_d  = lt_c;
        ltu_d = ltu_c;
        if (br_q) begin
          res_d   = 32'd0;
          taken_d = taken_c;
          state_d = RESP;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        taken_d = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_operation = 3'b000;
    alu_control   = 1'b0;
    alu_lt        = 1'b0;
    alu_ltu       = 1'b0;
    unique case (state_q)
      CMP: alu_control = 1'b1;
      EXEC: begin
        alu_operation = f3_q;
        alu_lt        = lt_q;
        alu_ltu       = ltu_q;
        if (f3_q == 3'b101)
          alu_control = f7_q;
        else if (f3_q == 3'b000 && !imm_q)
          alu_control = f7_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      f7_q    <= 1'b0;
      imm_q   <= 1'b0;
      br_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      ltu_q   <= 1'b0;
      res_q   <= '0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f3_q    <= f3_d;
      f7_q    <= f7_d;
      imm_q   <= imm_d;
      br_q    <= br_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      ltu_q   <= ltu_d;
      res_q   <= res_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_result = res_q;
  assign rsp_taken  = taken_q;
  assign op_count   = cnt_q;

endmodule
